// File: rtl/branch_history_predictor_if.sv
// Fetch-side lookup and execute-side training signals of the branch predictor.
// GHR fields stay one bit wide when history is disabled (GHR_W = 0).
interface branch_history_predictor_if #(
  parameter int PC_W  = 32,
  parameter int GHR_W = 6
);
  localparam int GW = (GHR_W > 0) ? GHR_W : 1;

  logic            pred_valid;
  logic [PC_W-1:0] pred_pc;
  logic            pred_out_valid;
  logic            pred_taken;
  logic [GW-1:0]   pred_ghr;

  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic [GW-1:0]   upd_ghr;
  logic            upd_taken;
  logic            upd_mispredict;

  modport master (
    output pred_valid, pred_pc,
    output upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
    input  pred_out_valid, pred_taken, pred_ghr
  );

  modport slave (
    input  pred_valid, pred_pc,
    input  upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
    output pred_out_valid, pred_taken, pred_ghr
  );
endinterface

// File: rtl/branch_history_predictor.sv
// Table of saturating direction counters indexed by PC, optionally XORed with a
// speculative global history (gshare); registered one-cycle lookup, EX-side training.
module branch_history_predictor #(
  parameter int ENTRIES  = 64,
  parameter int CTR_W    = 2,
  parameter int GHR_W    = 6,
  parameter int PC_W     = 32,
  parameter int ADDR_LSB = 2,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  branch_history_predictor_if.slave bus,
  output logic [CNT_W-1:0]          stat_updates,
  output logic [CNT_W-1:0]          stat_mispred
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int GW    = (GHR_W > 0) ? GHR_W : 1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  logic [CTR_W-1:0] ctr [ENTRIES];
  logic [GW-1:0]    ghr;
  logic [GW-1:0]    ghr_next;
  logic [IDX_W-1:0] ghr_term;
  logic [IDX_W-1:0] upd_ghr_term;
  logic [IDX_W-1:0] pidx;
  logic [IDX_W-1:0] uidx;
  logic             pred_bit;
  logic             out_valid_q;
  logic             out_taken_q;
  logic [GW-1:0]    out_ghr_q;
  logic             unused_bits;

  // With history disabled both XOR terms collapse to zero (pure bimodal).
  always_comb begin
    ghr_term     = '0;
    upd_ghr_term = '0;
    if (GHR_W > 0) begin
      ghr_term     = IDX_W'(ghr);
      upd_ghr_term = IDX_W'(bus.upd_ghr);
    end
  end

  assign pidx     = bus.pred_pc[ADDR_LSB +: IDX_W] ^ ghr_term;
  assign uidx     = bus.upd_pc[ADDR_LSB +: IDX_W] ^ upd_ghr_term;
  assign pred_bit = ctr[pidx][CTR_W-1];

  // A mispredict repair overrides any speculative shift from a lookup in the same cycle.
  always_comb begin
    ghr_next = ghr;
    if (GHR_W == 0) begin
      ghr_next = '0;
    end else if (bus.upd_valid && bus.upd_mispredict) begin
      ghr_next = GW'({bus.upd_ghr, bus.upd_taken});
    end else if (bus.pred_valid) begin
      ghr_next = GW'({ghr, pred_bit});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= CTR_INIT;
      end
    end else if (bus.upd_valid) begin
      if (bus.upd_taken) begin
        if (ctr[uidx] != CTR_MAX) ctr[uidx] <= ctr[uidx] + CTR_W'(1);
      end else begin
        if (ctr[uidx] != '0) ctr[uidx] <= ctr[uidx] - CTR_W'(1);
      end
    end
  end

  // Lookup reads the pre-update table, so a same-index update is not bypassed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr         <= '0;
      out_valid_q <= 1'b0;
      out_taken_q <= 1'b0;
      out_ghr_q   <= '0;
    end else begin
      ghr         <= ghr_next;
      out_valid_q <= bus.pred_valid;
      out_taken_q <= bus.pred_valid & pred_bit;
      if (bus.pred_valid) out_ghr_q <= ghr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_updates <= '0;
      stat_mispred <= '0;
    end else if (bus.upd_valid) begin
      stat_updates <= stat_updates + CNT_W'(1);
      if (bus.upd_mispredict) stat_mispred <= stat_mispred + CNT_W'(1);
    end
  end

  assign bus.pred_out_valid = out_valid_q;
  assign bus.pred_taken     = out_taken_q;
  assign bus.pred_ghr       = out_ghr_q;

  // PC bits outside the index window carry no information for the predictor.
  assign unused_bits = ^{bus.pred_pc, bus.upd_pc, bus.upd_ghr};
endmodule
